// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard detection and EX operand-forwarding select generation.
// Tracks EX/MEM destination registers and raises a one-cycle load-use stall.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_v_q, ex_wr_q, ex_ld_q;
    logic [REG_AW-1:0] ex_dst_q;
    logic              mem_v_q, mem_wr_q;
    logic [REG_AW-1:0] mem_dst_q;

    logic              ex_v_d;
    logic [1:0]        fwd_a_d, fwd_b_d;
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic              bubble_d, bubble_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    logic              ex_match_a, ex_match_b;
    logic              mem_match_a, mem_match_b;
    logic              haz_a, haz_b;
    logic [1:0]        sel_a, sel_b;
    logic              load_sel;

    // Register 0 is hard-wired, so it never has a producer.
    always_comb begin
        ex_match_a  = id_use_rs && ex_v_q && ex_wr_q
                      && (ex_dst_q == id_rs) && (id_rs != '0);
        ex_match_b  = id_use_rt && ex_v_q && ex_wr_q
                      && (ex_dst_q == id_rt) && (id_rt != '0);
        mem_match_a = id_use_rs && mem_v_q && mem_wr_q
                      && (mem_dst_q == id_rs) && (id_rs != '0);
        mem_match_b = id_use_rt && mem_v_q && mem_wr_q
                      && (mem_dst_q == id_rt) && (id_rt != '0);
    end

    always_comb begin
        haz_a = ex_match_a && ex_ld_q;
        haz_b = ex_match_b && ex_ld_q;
    end

    // The EX producer is newer than the MEM producer and takes priority.
    always_comb begin
        sel_a = SEL_RF;
        if (ex_match_a)       sel_a = SEL_MEM;
        else if (mem_match_a) sel_a = SEL_WB;
    end

    always_comb begin
        sel_b = SEL_RF;
        if (ex_match_b)       sel_b = SEL_MEM;
        else if (mem_match_b) sel_b = SEL_WB;
    end

    assign stall = id_valid && !flush && (haz_a || haz_b);

    always_comb begin
        load_sel = id_valid && !flush && !stall;
        ex_v_d   = load_sel;
        bubble_d = !load_sel;
        fwd_a_d  = load_sel ? sel_a : SEL_RF;
        fwd_b_d  = load_sel ? sel_b : SEL_RF;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_q    <= 1'b0;
            ex_wr_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            ex_dst_q  <= '0;
            mem_v_q   <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_dst_q <= '0;
        end else begin
            ex_v_q    <= ex_v_d;
            ex_wr_q   <= id_regwrite;
            ex_ld_q   <= id_memread;
            ex_dst_q  <= id_dst;
            mem_v_q   <= ex_v_q;
            mem_wr_q  <= ex_wr_q;
            mem_dst_q <= ex_dst_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
            bubble_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= bubble_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign ex_bubble = bubble_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: scoreboard of expected EX-stage selects.
`timescale 1ns/1ps
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic        flush;

    logic        stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        ex_bubble;
    logic [15:0] stall_cnt;

    logic        s_stall;
    logic [1:0]  s_a, s_b;
    logic        s_bub;
    logic [3:0]  s_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  sb_q[$];
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
    );

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush),
        .stall(s_stall), .fwd_a_sel(s_a), .fwd_b_sel(s_b),
        .ex_bubble(s_bub), .stall_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] dst,
                         input logic wr, input logic ld, input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_use_rs   = urs;
        id_rt       = rt;
        id_use_rt   = urt;
        id_dst      = dst;
        id_regwrite = wr;
        id_memread  = ld;
        flush       = fl;
    endtask

    // One ID cycle: drive, check stall, push EX expectation, clock, pop.
    task automatic step(input string tag, input logic v,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] dst, input logic wr,
                        input logic ld, input logic fl,
                        input logic e_stall, input logic [1:0] e_a,
                        input logic [1:0] e_b, input logic e_bub);
        logic [4:0] e;
        @(negedge clk);
        drive(v, rs, urs, rt, urt, dst, wr, ld, fl);
        #1;
        chk({tag, ".stall"}, {15'd0, stall}, {15'd0, e_stall});
        sb_q.push_back({e_a, e_b, e_bub});
        if (e_stall) exp_cnt++;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".fwd_a"}, {14'd0, fwd_a_sel}, {14'd0, e[4:3]});
            chk({tag, ".fwd_b"}, {14'd0, fwd_b_sel}, {14'd0, e[2:1]});
            chk({tag, ".bubble"}, {15'd0, ex_bubble}, {15'd0, e[0]});
        end
        chk({tag, ".cnt"}, stall_cnt, 16'(exp_cnt));
        chk({tag, ".cnt4"}, {12'd0, s_cnt},
            16'((exp_cnt > 15) ? 15 : exp_cnt));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst.stall", {15'd0, stall}, 16'd0);
        chk("rst.fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("rst.fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        chk("rst.bubble", {15'd0, ex_bubble}, 16'd1);
        chk("rst.cnt", stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // dependent ALU chain
        step("add_r3", 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step("sub_r3", 1, 5'd3, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 2'b10, 2'b00, 0);
        // distance-2 producer on rt
        step("add_r5", 1, 5'd1, 1, 5'd1, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step("or_r8", 1, 5'd2, 1, 5'd9, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step("and_r5", 1, 5'd1, 1, 5'd5, 1, 5'd10, 1, 0, 0, 0, 2'b00, 2'b01, 0);
        // load-use
        step("lw_r7", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        step("use_r7", 1, 5'd7, 1, 5'd2, 1, 5'd11, 1, 0, 0, 1, 2'b00, 2'b00, 1);
        step("held_r7", 1, 5'd7, 1, 5'd2, 1, 5'd11, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        // register 0
        step("wr_r0", 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step("use_r0", 1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        // double producer
        step("r4_a", 1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step("r4_b", 1, 5'd2, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step("use_r4", 1, 5'd4, 1, 5'd4, 1, 5'd12, 1, 0, 0, 0, 2'b10, 2'b10, 0);
        // flush beats stall
        step("lw_r9", 1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        step("flush_r9", 1, 5'd9, 1, 5'd9, 1, 5'd15, 1, 0, 1, 0, 2'b00, 2'b00, 1);
        step("invalid", 0, 5'd9, 1, 5'd9, 1, 5'd15, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        // unused sources
        step("lw_r13", 1, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        step("nouse_r13", 1, 5'd13, 0, 5'd13, 0, 5'd16, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        // reset mid-stall
        step("lw_r14", 1, 5'd1, 1, 5'd0, 0, 5'd14, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        @(negedge clk);
        drive(1, 5'd14, 1, 5'd0, 0, 5'd17, 1, 0, 0);
        #1;
        chk("pre_rst.stall", {15'd0, stall}, 16'd1);
        chk("pre_rst.cnt", stall_cnt, 16'(exp_cnt));
        rst = 1'b1;
        #1;
        chk("mid_rst.stall", {15'd0, stall}, 16'd0);
        chk("mid_rst.fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("mid_rst.fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        chk("mid_rst.bubble", {15'd0, ex_bubble}, 16'd1);
        chk("mid_rst.cnt", stall_cnt, 16'd0);
        chk("mid_rst.cnt4", {12'd0, s_cnt}, 16'd0);
        exp_cnt = 0;
        sb_q.delete();
        #1;
        rst = 1'b0;

        // repeated self-dependent loads: stall every other cycle
        for (int k = 0; k < 40; k++) begin
            step($sformatf("sat%0d", k), 1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 1, 0,
                 k[0], (k >= 2 && !k[0]) ? 2'b01 : 2'b00, 2'b00, k[0]);
        end
        chk("sat.final16", stall_cnt, 16'd20);
        chk("sat.final4", {12'd0, s_cnt}, 16'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Decode-stage hazard and forwarding controller for the five-stage MIPS-lite pipeline. It tracks the destination register of each instruction in flight through EX and MEM and produces the 2-bit operand selects for the EX-stage 3-to-1 operand multiplexers. It also raises a one-cycle load-use stall and counts stall cycles. It sits beside the ID/EX pipeline register, and its select outputs advance into EX together with the instruction they belong to.

## Interface
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source register A of the ID instruction
- id_rt  in  REG_AW  source register B of the ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dst  in  REG_AW  destination register of the ID instruction
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  squash the ID instruction (taken branch or jump)
- stall  out  1  combinational; holds PC and IF/ID and inserts a bubble into EX
- fwd_a_sel  out  2  registered; operand A select used in EX
- fwd_b_sel  out  2  registered; operand B select used in EX
- ex_bubble  out  1  registered; the EX stage holds a bubble
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Select encoding:
  - 00: register-file value.
  - 01: WB result.
  - 10: MEM (ALU) result.
  - 11: never driven.
- Internal trackers:
  - EX tracker: ex_v, ex_dst, ex_wr, ex_ld.
  - MEM tracker: mem_v, mem_dst, mem_wr.
- Each clock, the ID instruction moves into the EX tracker and the EX tracker moves into the MEM tracker. On stall or flush, EX receives a bubble (ex_v=0) and MEM still receives the old EX contents.
- "Producer X matches reg r" means all of: X valid, X writes, X dst equals r, and r is nonzero. Register 0 never matches.
- Per source r (rs when id_use_rs; rt when id_use_rt), evaluated at ID:
  - EX tracker matches and ex_ld=1: load-use hazard.
  - Else, EX tracker matches: next select is 10.
  - Else, MEM tracker matches: next select is 01.
  - Else: next select is 00.
  - When both trackers match, the EX tracker (the newer producer) wins.
- A producer in WB while the consumer is in ID is covered by the register file's write-before-read. This block does not handle it.
- stall = id_valid & !flush & (load-use hazard on rs or rt).
- Unused sources (use flag = 0) never stall and always select 00.
- Select registers:
  - Load the next selects when there is no stall, no flush and id_valid=1.
  - Otherwise load 00/00.
- ex_bubble is registered as (stall | flush | !id_valid).
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset (asynchronous, takes effect immediately): all trackers invalid; fwd_a_sel=00, fwd_b_sel=00, ex_bubble=1, stall_cnt=0. stall is therefore 0.
- stall has zero latency. It is valid combinationally in the same cycle as the ID inputs.
- Selects and ex_bubble have one-cycle latency. They are valid during the cycle the instruction occupies EX.
- A load-use hazard stalls for exactly one cycle. In the next cycle the load is in the MEM tracker, the still-held consumer sees no hazard, and its select resolves to 01.
- flush and stall in the same cycle: flush wins, so stall=0 and a bubble is inserted.
- Reset asserted mid-stall: stall drops immediately, and the stall_cnt value is lost.

## Test plan
- Dependent ALU chain: add r3 at ID, then sub reading r3 next cycle. Required: sub's fwd_a_sel=10 in EX, stall=0 throughout.
- Distance-2 producer: r5 written, one unrelated instruction, then a consumer of r5 on rt. Required: fwd_b_sel=01, stall=0.
- Load-use: lw r7, then add reading r7 on rs. Required: stall=1 for exactly one cycle, ex_bubble=1 the next cycle, then add in EX with fwd_a_sel=01, and stall_cnt increments from 0 to 1.
- Register-0 and double-producer cases:
  - Producer writing r0, then a consumer of r0: selects remain 00, no stall.
  - r4 written twice back-to-back, then a consumer: required select 10 (the newest producer).
- Flush and reset:
  - flush asserted together with a load-use hazard: stall=0 and the bubble is inserted.
  - rst asserted mid-stream: all outputs return to their reset values within the same cycle.
- Counter saturation: with CNT_W=4, hold repeated load-use stalls for 20 cycles. Required: stall_cnt stops at 15.
